// File: rtl/controller_sequencer_if.sv
// Control-word bundle between the SAP-1 controller-sequencer and the datapath.
// The sequencer takes the master side; the datapath (or bench) takes the slave side.
interface controller_sequencer_if;
    logic [3:0] IR_OP;
    logic [5:0] T_STATE;
    logic       CP, EP, LM, CE, LI, EI, LA, EA, S_U, EU, LB, LO, HLT;

    modport master (
        input  IR_OP,
        output T_STATE, CP, EP, LM, CE, LI, EI, LA, EA, S_U, EU, LB, LO, HLT
    );

    modport slave (
        output IR_OP,
        input  T_STATE, CP, EP, LM, CE, LI, EI, LA, EA, S_U, EU, LB, LO, HLT
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring decoded with the IR opcode
// into the control word for LDA, ADD, SUB, OUT and HLT.
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic                   CLK,
    input  logic                   CLR,
    controller_sequencer_if.master bus
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state, state_nxt;
    logic     halted, halted_nxt;
    logic     cp, ep, lm, ce, li, ei, la, ea, s_u, eu, lb, lo, hlt;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        {cp, ep, lm, ce, li, ei, la, ea, s_u, eu, lb, lo, hlt} = '0;
        if (halted) begin
            // Frozen at T4 until CLR; opcode is no longer looked at.
            hlt = 1'b1;
        end else begin
            case (state)
                T1: begin ep = 1'b1; lm = 1'b1; state_nxt = T2; end
                T2: begin cp = 1'b1;            state_nxt = T3; end
                T3: begin ce = 1'b1; li = 1'b1; state_nxt = T4; end
                T4: begin
                    state_nxt = T5;
                    case (bus.IR_OP)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_OUT: begin ea = 1'b1; lo = 1'b1; end
                        OP_HLT: begin
                            hlt        = 1'b1;
                            halted_nxt = 1'b1;
                            state_nxt  = T4;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    state_nxt = T6;
                    case (bus.IR_OP)
                        OP_LDA:         begin ce = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    state_nxt = T1;
                    case (bus.IR_OP)
                        OP_ADD: begin eu = 1'b1; la = 1'b1; end
                        OP_SUB: begin eu = 1'b1; la = 1'b1; s_u = 1'b1; end
                        default: ;
                    endcase
                end
                // Non-one-hot encodings only arise before the first CLR; steer back into the ring.
                default: state_nxt = T1;
            endcase
        end
    end

    assign bus.T_STATE = state;
    assign bus.CP      = cp;
    assign bus.EP      = ep;
    assign bus.LM      = lm;
    assign bus.CE      = ce;
    assign bus.LI      = li;
    assign bus.EI      = ei;
    assign bus.LA      = la;
    assign bus.EA      = ea;
    assign bus.S_U     = s_u;
    assign bus.EU      = eu;
    assign bus.LB      = lb;
    assign bus.LO      = lo;
    assign bus.HLT     = hlt;
endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: the driver queues the expected
// control word for every cycle, a negedge monitor pops and compares.
module tb_controller_sequencer;
    logic CLK = 1'b0;
    logic CLR = 1'b1;
    controller_sequencer_if bus ();

    controller_sequencer dut (.CLK(CLK), .CLR(CLR), .bus(bus.master));

    always #5 CLK = ~CLK;

    // Control word bit positions: {CP,EP,LM,CE,LI,EI,LA,EA,S_U,EU,LB,LO,HLT}
    localparam logic [12:0] W_CP = 13'h1000, W_EP = 13'h0800, W_LM = 13'h0400,
                            W_CE = 13'h0200, W_LI = 13'h0100, W_EI = 13'h0080,
                            W_LA = 13'h0040, W_EA = 13'h0020, W_SU = 13'h0010,
                            W_EU = 13'h0008, W_LB = 13'h0004, W_LO = 13'h0002,
                            W_HL = 13'h0001, W_0  = 13'h0000;

    typedef struct {
        string       name;
        logic [5:0]  t;
        logic [12:0] c;
        bit          alu_chk;
        logic [7:0]  alu_exp;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] reg_a = 8'h00;
    logic [7:0] reg_b = 8'h00;

    // Drive one cycle's inputs and queue what the outputs must be during that cycle.
    task automatic step(input string nm, input logic clr, input logic [3:0] op,
                        input logic [5:0] t, input logic [12:0] c,
                        input bit ac = 1'b0, input logic [7:0] ae = 8'h00);
        exp_t e;
        CLR       = clr;
        bus.IR_OP = op;
        e.name    = nm;
        e.t       = t;
        e.c       = c;
        e.alu_chk = ac;
        e.alu_exp = ae;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op);
        step("fetch_t1", 1'b0, op, 6'b000001, W_EP | W_LM);
        step("fetch_t2", 1'b0, op, 6'b000010, W_CP);
        step("fetch_t3", 1'b0, op, 6'b000100, W_CE | W_LI);
    endtask

    task automatic instr(input string nm, input logic [3:0] fop, input logic [3:0] op,
                         input logic [12:0] w4, input logic [12:0] w5, input logic [12:0] w6,
                         input bit ac = 1'b0, input logic [7:0] ae = 8'h00);
        fetch(fop);
        step({nm, "_t4"}, 1'b0, op, 6'b001000, w4);
        step({nm, "_t5"}, 1'b0, op, 6'b010000, w5);
        step({nm, "_t6"}, 1'b0, op, 6'b100000, w6, ac, ae);
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [12:0] got;
            logic [7:0]  alu;
            int          drivers;
            e   = sb.pop_front();
            got = {bus.CP, bus.EP, bus.LM, bus.CE, bus.LI, bus.EI, bus.LA,
                   bus.EA, bus.S_U, bus.EU, bus.LB, bus.LO, bus.HLT};
            tests++;
            if (bus.T_STATE !== e.t || got !== e.c) begin
                fails++;
                $display("FAIL %s: t_state got %b want %b, ctrl got %b want %b",
                         e.name, bus.T_STATE, e.t, got, e.c);
            end
            drivers = int'(bus.EP) + int'(bus.CE) + int'(bus.EI) + int'(bus.EA) + int'(bus.EU);
            tests++;
            if (drivers > 1) begin
                fails++;
                $display("FAIL bus_excl(%s): %0d bus drivers got, at most 1 required", e.name, drivers);
            end
            if (e.alu_chk) begin
                alu = bus.S_U ? reg_a - reg_b : reg_a + reg_b;
                tests++;
                if (bus.EU !== 1'b1 || alu !== e.alu_exp) begin
                    fails++;
                    $display("FAIL alu(%s): eu=%b sum got %h want %h", e.name, bus.EU, alu, e.alu_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.IR_OP = 4'h0;
        CLR       = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        step("reset_hold", 1'b1, 4'h0, 6'b000001, W_EP | W_LM);
        // NOP walks the full ring; fetch driven with HLT opcode to show fetch ignores IR_OP.
        instr("nop", 4'hF, 4'h7, W_0, W_0, W_0);
        instr("lda", 4'h0, 4'h0, W_EI | W_LM, W_CE | W_LA, W_0);
        reg_a = 8'h05; reg_b = 8'h03;
        instr("add", 4'h1, 4'h1, W_EI | W_LM, W_CE | W_LB, W_EU | W_LA, 1'b1, 8'h08);
        reg_a = 8'h05; reg_b = 8'h07;
        instr("sub", 4'h2, 4'h2, W_EI | W_LM, W_CE | W_LB, W_EU | W_LA | W_SU, 1'b1, 8'hFE);
        instr("out", 4'hE, 4'hE, W_EA | W_LO, W_0, W_0);
        step("wrap_t1", 1'b0, 4'h0, 6'b000001, W_EP | W_LM);
        step("wrap_t2", 1'b0, 4'h0, 6'b000010, W_CP);
        step("wrap_t3", 1'b0, 4'hF, 6'b000100, W_CE | W_LI);
        step("hlt_t4", 1'b0, 4'hF, 6'b001000, W_HL);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] op;
            op = (i % 2 == 0) ? 4'h1 : 4'h2;
            if (i % 5 == 4) op = 4'hE;
            step("hlt_hold", 1'b0, op, 6'b001000, W_HL);
        end
        step("hlt_clr", 1'b1, 4'h2, 6'b001000, W_HL);
        reg_a = 8'h05; reg_b = 8'h03;
        instr("post_hlt_add", 4'h1, 4'h1, W_EI | W_LM, W_CE | W_LB, W_EU | W_LA, 1'b1, 8'h08);
        // Abort a SUB in T5: the next state must be a clean T1 fetch.
        fetch(4'h2);
        step("mid_t4", 1'b0, 4'h2, 6'b001000, W_EI | W_LM);
        step("mid_clr_t5", 1'b1, 4'h2, 6'b010000, W_CE | W_LB);
        reg_a = 8'h05; reg_b = 8'h07;
        instr("post_mid_sub", 4'h2, 4'h2, W_EI | W_LM, W_CE | W_LB, W_EU | W_LA | W_SU, 1'b1, 8'hFE);
        @(negedge CLK);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, 0 required", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
